// File: rtl/i2s_tx_frame_pkg.sv
// Shared constants and frame type for the I2S/TDM frame transmitter.
// Defaults describe the 2ch/24b PMOD DAC output path.
package i2s_tx_frame_pkg;

  localparam int I2S_SAMPLE_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH   = 24;
  localparam int I2S_NUM_CH       = 2;
  localparam int I2S_FIFO_DEPTH   = 4;
  localparam int I2S_MCLK_DIV     = 2;
  localparam int I2S_SCLK_DIV     = 4;

  typedef logic [I2S_NUM_CH*I2S_SAMPLE_WIDTH-1:0] i2s_frame_t;

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous frame FIFO with occupancy count and async active-high reset.
// Push when full or pop when empty is ignored; no pass-through.
module i2s_frame_fifo
  import i2s_tx_frame_pkg::*;
#(
  parameter int WIDTH = I2S_NUM_CH*I2S_SAMPLE_WIDTH,
  parameter int DEPTH = I2S_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (fill == DEPTH_V);
  assign empty    = (fill == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      fill <= fill + 1'b1;
      else if (do_pop && !do_push) fill <= fill - 1'b1;
    end
  end

  // frame storage; contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2s_tx_frame.sv
// I2S/TDM frame transmitter: FIFO, MCLK/SCLK/LRCK generation, MSB-first serialiser.
// Build option I2S_TX_HOLD_LAST_EN: repeat last fetched frame on underrun.
module i2s_tx_frame
  import i2s_tx_frame_pkg::*;
#(
  parameter int SAMPLE_WIDTH = I2S_SAMPLE_WIDTH,
  parameter int SLOT_WIDTH   = I2S_SLOT_WIDTH,
  parameter int NUM_CH       = I2S_NUM_CH,
  parameter int FIFO_DEPTH   = I2S_FIFO_DEPTH,
  parameter int MCLK_DIV     = I2S_MCLK_DIV,
  parameter int SCLK_DIV     = I2S_SCLK_DIV
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] frame_in,
  input  logic                           frame_valid_in,
  output logic                           frame_ready_out,
  output logic [$clog2(FIFO_DEPTH):0]    fill_out,
  output logic                           underrun_out,
  output logic                           mclk_out,
  output logic                           sclk_out,
  output logic                           lrck_out,
  output logic                           sdin_out
);

  localparam int FB = NUM_CH*SLOT_WIDTH;
  localparam int FW = NUM_CH*SAMPLE_WIDTH;
  localparam int DW = $clog2(SCLK_DIV) + 1;
  localparam int BW = $clog2(FB);

  localparam logic [DW-1:0] DIV_MAX  = DW'(SCLK_DIV-1);
  localparam logic [DW-1:0] S_HALF   = DW'(SCLK_DIV/2);
  localparam logic [DW-1:0] M_DIV    = DW'(MCLK_DIV);
  localparam logic [DW-1:0] M_HALF   = DW'(MCLK_DIV/2);
  localparam logic [BW-1:0] BIT_MAX  = BW'(FB-1);
  localparam logic [BW-1:0] BIT_HALF = BW'(FB/2);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [BW-1:0] bit_cnt;
  logic [BW-1:0] bit_nxt;
  logic [FB-1:0] shreg;
  logic [FB-1:0] shreg_nxt;
  logic [FB-1:0] slots;
  logic [FW-1:0] head;
  logic [FW-1:0] src;
  logic          full;
  logic          empty;
  logic          wrap;
  logic          fetch;
  logic          pop;

  i2s_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (frame_valid_in),
    .push_data (frame_in),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .fill      (fill_out)
  );

  assign frame_ready_out = !full && !rst_in;

`ifdef I2S_TX_HOLD_LAST_EN
  logic [FW-1:0] last_frame;

  // remember the most recent frame actually taken from the FIFO
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)   last_frame <= '0;
    else if (pop) last_frame <= head;
  end

  assign src = empty ? last_frame : head;
`else
  assign src = empty ? '0 : head;
`endif

  // divider/bit-counter steps, fetch strobe and slot layout of the next frame
  always_comb begin
    wrap    = (div_cnt == DIV_MAX);
    div_nxt = wrap ? '0 : div_cnt + 1'b1;
    bit_nxt = (bit_cnt == BIT_MAX) ? '0 : bit_cnt + 1'b1;
    fetch   = wrap && (bit_nxt == BIT_ONE);
    pop     = fetch && !empty;
    slots   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      slots[FB-1-k*SLOT_WIDTH -: SAMPLE_WIDTH] =
        src[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
    shreg_nxt = fetch ? slots : {shreg[FB-2:0], 1'b0};
  end

  // clocks every cycle; serial state only on the SCLK falling edge
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      sclk_out     <= 1'b0;
      mclk_out     <= 1'b0;
      lrck_out     <= 1'b0;
      sdin_out     <= 1'b0;
      underrun_out <= 1'b0;
    end else begin
      div_cnt      <= div_nxt;
      sclk_out     <= (div_nxt >= S_HALF);
      mclk_out     <= ((div_nxt % M_DIV) >= M_HALF);
      underrun_out <= fetch && empty;
      if (wrap) begin
        bit_cnt  <= bit_nxt;
        lrck_out <= (bit_nxt >= BIT_HALF);
        shreg    <= shreg_nxt;
        sdin_out <= shreg_nxt[FB-1];
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_frame.sv
// Randomised bench for i2s_tx_frame (4ch, 32-bit slots, 24-bit samples).
// Reference model: frame queue plus position arithmetic from elapsed cycles.
module tb_i2s_tx_frame;

  localparam int NCH   = 4;
  localparam int SW    = 24;
  localparam int SLOT  = 32;
  localparam int DEPTH = 4;
  localparam int MD    = 2;
  localparam int SD    = 4;
  localparam int FB    = NCH*SLOT;
  localparam int FW    = NCH*SW;
`ifdef I2S_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [FW-1:0] frame_in = '0;
  logic          frame_valid_in = 1'b0;
  logic          frame_ready_out;
  logic [2:0]    fill_out;
  logic          underrun_out;
  logic          mclk_out;
  logic          sclk_out;
  logic          lrck_out;
  logic          sdin_out;

  i2s_tx_frame #(
    .SAMPLE_WIDTH (SW),
    .SLOT_WIDTH   (SLOT),
    .NUM_CH       (NCH),
    .FIFO_DEPTH   (DEPTH),
    .MCLK_DIV     (MD),
    .SCLK_DIV     (SD)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .frame_in        (frame_in),
    .frame_valid_in  (frame_valid_in),
    .frame_ready_out (frame_ready_out),
    .fill_out        (fill_out),
    .underrun_out    (underrun_out),
    .mclk_out        (mclk_out),
    .sclk_out        (sclk_out),
    .lrck_out        (lrck_out),
    .sdin_out        (sdin_out)
  );

  always #5 clk_in = ~clk_in;

  int            tests = 0;
  int            fails = 0;
  int            n = 0;
  logic [FW-1:0] q[$];
  logic [FW-1:0] cur = '0;
  logic [FW-1:0] hold = '0;
  bit            exp_under = 1'b0;
  bit            m_fetch;
  bit            m_acc;
  int            per;
  int            bpos;
  logic          e_sd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // serial bit j (0 = first sent) of a frame: sample MSB-first, then zero pad
  function automatic logic fbit(input logic [FW-1:0] f, input int j);
    int s;
    int o;
    s = j / SLOT;
    o = j % SLOT;
    if (o >= SW) return 1'b0;
    return f[s*SW + SW-1-o];
  endfunction

  // model state advanced once per clock: elapsed edges, FIFO queue, fetched frame
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      n = 0;
      q.delete();
      cur = '0;
      hold = '0;
      exp_under = 1'b0;
    end else begin
      n++;
      m_fetch = (n % SD == 0) && ((n / SD) % FB == 1);
      m_acc = frame_valid_in && (q.size() < DEPTH);
      exp_under = m_fetch && (q.size() == 0);
      if (m_fetch) begin
        if (q.size() > 0) begin
          cur = q.pop_front();
          hold = cur;
        end else begin
          cur = HOLD ? hold : '0;
        end
      end
      if (m_acc) q.push_back(frame_in);
    end
  end

  // compare every output mid-cycle against the model
  always @(negedge clk_in) begin
    per  = n / SD;
    bpos = per % FB;
    e_sd = (bpos == 0) ? fbit(cur, FB-1) : fbit(cur, bpos-1);
    chk("sclk", sclk_out, 32'((n % SD) >= SD/2));
    chk("mclk", mclk_out, 32'((n % MD) >= MD/2));
    chk("lrck", lrck_out, 32'(bpos >= FB/2));
    chk("sdin", sdin_out, 32'(e_sd));
    chk("underrun", underrun_out, 32'(exp_under));
    chk("fill", fill_out, 32'(q.size()));
    chk("ready", frame_ready_out, 32'(!rst_in && q.size() < DEPTH));
  end

  function automatic logic [SW-1:0] rsamp();
    case ($urandom_range(5))
      0: return 24'hFFFFFF;
      1: return 24'h800001;
      2: return 24'h7FFFFE;
      default: return SW'($urandom);
    endcase
  endfunction

  task automatic run(input int cycles, input int pct);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_in);
      #2;
      for (int k = 0; k < NCH; k++) frame_in[k*SW +: SW] = rsamp();
      frame_valid_in = ($urandom_range(99) < pct);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    frame_in = {24'h000000, 24'hFFFFFF, 24'h7FFFFE, 24'h800001};
    frame_valid_in = 1'b1;
    @(posedge clk_in);
    #2;
    frame_valid_in = 1'b0;
    run(600, 0);
    run(3000, 40);
    run(1600, 0);
    run(2000, 100);
    run(1000, 30);
    begin
      int waited;
      waited = 0;
      while (((n / SD) % FB) != 10 && waited < 2000) begin
        @(posedge clk_in);
        #2;
        waited++;
      end
      chk("wait_bit10", 32'(((n / SD) % FB) == 10), 32'd1);
    end
    rst_in = 1'b1;
    #1;
    chk("rst_sdin", sdin_out, 32'd0);
    chk("rst_lrck", lrck_out, 32'd0);
    chk("rst_sclk", sclk_out, 32'd0);
    chk("rst_mclk", mclk_out, 32'd0);
    chk("rst_fill", fill_out, 32'd0);
    chk("rst_ready", frame_ready_out, 32'd0);
    repeat (2) @(posedge clk_in);
    #2;
    rst_in = 1'b0;
    run(700, 0);
    run(2500, 50);
    run(800, 0);
    frame_valid_in = 1'b0;
    @(negedge clk_in);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
